prog_counter: RTL

//   Parametrised programmable up/down counter, successor to the fixed 8-bit load/oe_n counter.

---
 rtl/prog_counter_if.sv | 33 +++
 rtl/prog_counter.sv | 93 +++++++++
 2 files changed

// File: rtl/prog_counter_if.sv
// prog_counter_if: control and status bundle for prog_counter.
//   master modport: drives control inputs, observes count/status (wrapper or bench).
//   slave modport : the counter itself.
//   Signals: ena, load, load_sel, data[DATA_W], count_en, up_dn, sat_mode,
//            prescale[PRESCALE_W], oe_n -> count_out[WIDTH], tc_pulse, at_bound.
interface prog_counter_if #(
  parameter int WIDTH      = 8,
  parameter int DATA_W     = 6,
  parameter int PRESCALE_W = 4
);
  logic                  ena;
  logic                  load;
  logic                  load_sel;
  logic [DATA_W-1:0]     data;
  logic                  count_en;
  logic                  up_dn;
  logic                  sat_mode;
  logic [PRESCALE_W-1:0] prescale;
  logic                  oe_n;
  logic [WIDTH-1:0]      count_out;
  logic                  tc_pulse;
  logic                  at_bound;

  modport master (
    output ena, load, load_sel, data, count_en, up_dn, sat_mode, prescale, oe_n,
    input  count_out, tc_pulse, at_bound
  );

  modport slave (
    input  ena, load, load_sel, data, count_en, up_dn, sat_mode, prescale, oe_n,
    output count_out, tc_pulse, at_bound
  );
endinterface

// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with limit register, wrap or
// saturate boundary handling, clock-enable prescaler and a registered
// terminal-count pulse.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : prog_counter_if.slave (control in, count_out/tc_pulse/at_bound out)
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int DATA_W     = 6,
  parameter int PRESCALE_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_counter_if.slave bus
);

  logic [WIDTH-1:0]      count;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tc_pulse;

  logic                  tick;
  logic [WIDTH-1:0]      next_count;
  logic                  tc_event;

  // A step happens only when the prescaler has reached its compare value.
  assign tick = bus.count_en && (pre_cnt == bus.prescale);

  // Next count value for a tick, and whether that tick is a terminal event.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_count = count;
    tc_event   = 1'b0;
    if (bus.up_dn) begin
      if (count < limit) begin
        next_count = count + 1'b1;
        // In saturate mode, arriving on the limit is the terminal event.
        tc_event   = bus.sat_mode && (count + 1'b1 == limit);
      end else if (bus.sat_mode) begin
        // count > limit (after a limit reload) clamps and pulses; pinned does not.
        next_count = limit;
        tc_event   = (count != limit);
      end else begin
        next_count = '0;
        tc_event   = 1'b1;
      end
    end else begin
      if (count != '0) begin
        next_count = count - 1'b1;
        tc_event   = bus.sat_mode && (count == WIDTH'(1));
      end else if (!bus.sat_mode) begin
        next_count = limit;
        tc_event   = 1'b1;
      end
    end
  end

  // NOTE: reset is sampled on the clock edge here (synchronous), so rst_n is
  // deliberately absent from the sensitivity list; state uses non-blocking
  // assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      limit    <= '1;
      pre_cnt  <= '0;
      tc_pulse <= 1'b0;
    end else if (!bus.ena) begin
      tc_pulse <= 1'b0;
    end else if (bus.load) begin
      tc_pulse <= 1'b0;
      if (!bus.load_sel) begin
        count   <= WIDTH'(bus.data);
        pre_cnt <= '0;
      end else begin
        limit   <= WIDTH'(bus.data);
      end
    end else begin
      if (bus.count_en) begin
        // A prescale value lowered below pre_cnt lets pre_cnt run on and wrap.
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      end
      if (tick) begin
        count <= next_count;
      end
      tc_pulse <= tick && tc_event;
    end
  end

  assign bus.tc_pulse  = tc_pulse;
  assign bus.at_bound  = bus.up_dn ? (count >= limit) : (count == '0);
  assign bus.count_out = bus.oe_n ? '0 : count;

endmodule
